// File: rtl/platform_pkg.sv
// Platform-wide bus geometry shared by crossbar masters and slaves.
package platform_pkg;
  localparam int unsigned SEC_WB_AW = 32;
  localparam int unsigned SEC_WB_DW = 128;
endpackage

// File: rtl/video_line_fetcher_if.sv
// Pipelined Wishbone bus bundle (cyc/stb/stall handshake) with master and slave views.
interface wishbone_if
  import platform_pkg::*;
#(
  parameter int unsigned AW = SEC_WB_AW,
  parameter int unsigned DW = SEC_WB_DW
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW/8-1:0] sel;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          ack;
  logic          err;
  logic          rty;
  logic          stall;

  modport MASTER (
    output cyc, stb, we, adr, sel, dat_w,
    input  dat_r, ack, err, rty, stall
  );

  modport SLAVE (
    input  cyc, stb, we, adr, sel, dat_w,
    output dat_r, ack, err, rty, stall
  );
endinterface

// File: rtl/video_line_fetcher.sv
// Streams one framebuffer of 128-bit words over pipelined Wishbone reads into a FWFT pixel FIFO.
// Define VIDEO_FETCH_UNDERFLOW_CNT_EN to build the saturating pixel-side underflow counter.
module video_line_fetcher
  import platform_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = 19200,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  wishbone_if.MASTER           wb_if,
  input  logic [SEC_WB_AW-1:0] fb_base_i,
  input  logic                 sof_i,
  input  logic                 pix_rd_i,
  output logic [SEC_WB_DW-1:0] pix_data_o,
  output logic                 pix_valid_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [15:0]          underflow_cnt_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CRD_W = CNT_W + 1;
  localparam int unsigned ISS_W = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT} state_e;

  state_e               state_q, state_n;
  logic                 cyc_q, cyc_n;
  logic                 stb_q, stb_n;
  logic                 busy_q, err_q, valid_q;
  logic [SEC_WB_AW-1:0] addr_q;
  logic [ISS_W-1:0]     issued_q, issued_adv_c;
  logic [CNT_W-1:0]     out_q, out_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [SEC_WB_DW-1:0] mem_q [FIFO_DEPTH];

  logic accept_c, ack_c, bus_err_c, push_c, pop_c, start_c, credit_c;
  logic unused_rty_c;

  // Bus responses only count while a cycle is open; late acks after an abort are dropped.
  assign accept_c     = stb_q & ~wb_if.stall;
  assign ack_c        = cyc_q & wb_if.ack;
  assign bus_err_c    = cyc_q & wb_if.err;
  assign push_c       = ack_c;
  assign pop_c        = pix_rd_i & valid_q;
  assign start_c      = (state_q == IDLE) & sof_i;
  assign unused_rty_c = wb_if.rty;

  assign cnt_n        = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
  assign out_n        = bus_err_c ? '0 : (out_q + CNT_W'(accept_c) - CNT_W'(ack_c));
  assign issued_adv_c = issued_q + ISS_W'(accept_c);
  // Credit counts words already buffered plus reads still in flight.
  assign credit_c     = (CRD_W'(cnt_n) + CRD_W'(out_n)) < CRD_W'(FIFO_DEPTH);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cyc_q   <= cyc_n;
      stb_q   <= stb_n;
      busy_q  <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state_q;
    cyc_n   = cyc_q;
    stb_n   = stb_q;
    unique case (state_q)
      IDLE: begin
        cyc_n = 1'b0;
        stb_n = 1'b0;
        if (sof_i) begin
          state_n = FETCH;
          cyc_n   = 1'b1;
          stb_n   = credit_c;
        end
      end
      FETCH: begin
        if (stb_q && wb_if.stall) begin
          stb_n = 1'b1;
        end else if (issued_adv_c == ISS_W'(FRAME_WORDS)) begin
          state_n = WAIT;
          stb_n   = 1'b0;
        end else if (accept_c && !credit_c) begin
          state_n = WAIT;
          stb_n   = 1'b0;
        end else begin
          stb_n = credit_c;
        end
      end
      WAIT: begin
        stb_n = 1'b0;
        // Drain in-flight reads with cyc held, then decide only after cyc has been low a cycle.
        if (cyc_q) begin
          if (out_n == '0) cyc_n = 1'b0;
        end else if (issued_q == ISS_W'(FRAME_WORDS)) begin
          state_n = IDLE;
        end else if (credit_c) begin
          state_n = FETCH;
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cyc_n   = 1'b0;
        stb_n   = 1'b0;
      end
    endcase
    if (bus_err_c) begin
      state_n = IDLE;
      cyc_n   = 1'b0;
      stb_n   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_q   <= '0;
      issued_q <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (start_c) begin
        addr_q   <= fb_base_i;
        issued_q <= '0;
      end else if (accept_c) begin
        addr_q   <= addr_q + SEC_WB_AW'(1);
        issued_q <= issued_adv_c;
      end
      out_q <= out_n;
      if (bus_err_c || (sof_i && state_q != IDLE)) err_q <= 1'b1;
    end
  end

  // FIFO bookkeeping; pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q   <= cnt_n;
      valid_q <= (cnt_n != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wr_ptr_q] <= wb_if.dat_r;
  end

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(push_c && cnt_q == CNT_W'(FIFO_DEPTH)));

`ifdef VIDEO_FETCH_UNDERFLOW_CNT_EN
  logic [15:0] uf_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      uf_q <= '0;
    end else if (pix_rd_i && !valid_q && uf_q != 16'hFFFF) begin
      uf_q <= uf_q + 16'd1;
    end
  end

  assign underflow_cnt_o = uf_q;
`else
  assign underflow_cnt_o = 16'd0;
`endif

  assign wb_if.cyc   = cyc_q;
  assign wb_if.stb   = stb_q;
  assign wb_if.we    = 1'b0;
  assign wb_if.adr   = addr_q;
  assign wb_if.sel   = '1;
  assign wb_if.dat_w = '0;

  assign pix_data_o  = mem_q[rd_ptr_q];
  assign pix_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: doc/video_line_fetcher.md
VIDEO_LINE_FETCHER -- requirements
Module: video_line_fetcher

Interface
REQ-001 Parameters SHALL be: FRAME_WORDS, default 19200, is the number of 128-bit words per frame; FIFO_DEPTH, default 16, is the read-buffer depth in words and SHALL be a power of 2.
REQ-002 Bus widths SHALL be SEC_WB_AW and SEC_WB_DW=128, taken from platform_pkg.
REQ-003 Port clk_i: input, 1 bit, the single clock; everything is synchronous to its rising edge.
REQ-004 Port rstn_i: input, 1 bit, active-low asynchronous reset.
REQ-005 Port wb_if: wishbone_if.MASTER, SEC_WB_AW/SEC_WB_DW, pipelined read master into the secondary-crossbar video master slot.
REQ-006 Port fb_base_i: input, SEC_WB_AW bits, framebuffer base word address; sampled on sof_i.
REQ-007 Port sof_i: input, 1 bit, single-cycle start-of-frame pulse.
REQ-008 Port pix_rd_i: input, 1 bit, pixel-side pop request.
REQ-009 Port pix_data_o: output, 128 bits, FIFO head word.
REQ-010 Port pix_valid_o: output, 1 bit, high when the FIFO is not empty.
REQ-011 Port busy_o: output, 1 bit, high when the FSM is not IDLE.
REQ-012 Port err_o: output, 1 bit, sticky flag set by a bus error or by an sof_i pulse while busy.
REQ-013 Port underflow_cnt_o: output, 16 bits, counts pops attempted while the FIFO is empty (see Configuration).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, FETCH and WAIT.
REQ-015 IDLE with sof_i=1: latch addr=fb_base_i, issued=0, err_o unchanged, then go to FETCH.
REQ-016 FETCH: cyc=1; stb=1 only when credit exists and issued<FRAME_WORDS; we=0; sel='1; wdata='0.
REQ-017 Credit SHALL mean fifo_count + outstanding < FIFO_DEPTH.
REQ-018 A request SHALL be accepted on a cycle with stb=1 and stall=0; on acceptance, addr+1, issued+1 and outstanding+1.
REQ-019 While stall=1, addr and stb SHALL be held stable.
REQ-020 Each ack SHALL decrement outstanding and push rdata into the FIFO in the same cycle; an ack and an acceptance in the same cycle leave outstanding unchanged.
REQ-021 FETCH SHALL go to WAIT when issued==FRAME_WORDS, or when there is no credit after an acceptance.
REQ-022 WAIT SHALL hold cyc=1, stb=0 until outstanding==0, then drop cyc for at least one cycle.
REQ-023 When WAIT ends, the next state SHALL be FETCH if issued<FRAME_WORDS and credit exists, IDLE if issued==FRAME_WORDS, and otherwise remain in WAIT with cyc=0.
REQ-024 An err in any state SHALL: set err_o, drop cyc/stb the next cycle, clear outstanding, and go to IDLE; the FIFO contents SHALL be kept.
REQ-025 An sof_i pulse while busy SHALL set err_o and SHALL NOT restart or alter the fetch.
REQ-026 The FIFO SHALL be first-word fall-through; pix_data_o SHALL be valid in the same cycle as pix_valid_o.
REQ-027 A pop occurs on pix_rd_i & pix_valid_o.
REQ-028 A push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 The credit rule SHALL make push-when-full impossible; a push when full SHALL be covered by an assertion.
REQ-031 pix_rd_i while empty SHALL NOT pop, and SHALL NOT change the FIFO.
REQ-032 rty from the bus SHALL be ignored.

Reset
REQ-033 On rstn_i=0, asynchronously: state=IDLE; cyc=stb=0; addr, issued, outstanding and FIFO pointers=0; err_o=0; underflow_cnt_o=0; pix_valid_o=0.
REQ-034 Reset asserted mid-burst SHALL drop cyc immediately; acks arriving after release SHALL be discarded while in IDLE.

Configuration
REQ-035 With macro VIDEO_FETCH_UNDERFLOW_CNT_EN defined, underflow_cnt_o SHALL increment by 1 per cycle with pix_rd_i=1 and pix_valid_o=0, saturating at 16'hFFFF.
REQ-036 Without VIDEO_FETCH_UNDERFLOW_CNT_EN, underflow_cnt_o SHALL be tied to 0 and no counter logic SHALL be built.

Verification
REQ-037 FRAME_WORDS=4, base=0x100, slave acks 1 cycle after each accept, no stall -> addresses 0x100..0x103 issued; 4 words pushed in order; busy_o falls after cyc drops.
REQ-038 FIFO_DEPTH=4, pix_rd_i=0, FRAME_WORDS=8 -> exactly 4 requests issued; stb low until a pop; 5th request issued only after a pop.
REQ-039 Stall held 3 cycles on the 2nd request -> addr and stb stable throughout the stall; no duplicate or skipped address.
REQ-040 err on the 3rd ack -> err_o=1; cyc=0 the next cycle; state IDLE; first 2 words still poppable.
REQ-041 sof_i pulse while busy -> err_o=1; address sequence unaffected; frame completes normally.
REQ-042 With VIDEO_FETCH_UNDERFLOW_CNT_EN defined: pix_rd_i=1 for 5 cycles on an empty FIFO -> underflow_cnt_o=5. Without the macro: underflow_cnt_o stays 0.
